// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, including fetch state encodings, instruction lengths and the reset PC.
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_B0   = 3'd2,
    S_B1   = 3'd3,
    S_B2   = 3'd4,
    S_OUT  = 3'd5
  } fetch_state_t;
  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h1000;
endpackage

// File: rtl/opcode_length.sv
// opcode_length: byte length of an NMOS 6502 opcode plus an illegal flag; illegal opcodes report length 1.
module opcode_length
  import cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [1:0] o_len,
  output logic       o_illegal
);
  always_comb begin
    o_len = LEN_1;
    o_illegal = 1'b0;
    case (i_opcode)
      8'h00, 8'h08, 8'h0A, 8'h18, 8'h28, 8'h2A, 8'h38, 8'h40, 8'h48, 8'h4A,
      8'h58, 8'h60, 8'h68, 8'h6A, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8,
      8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8: ;
      8'h01, 8'h05, 8'h06, 8'h09, 8'h10, 8'h11, 8'h15, 8'h16,
      8'h21, 8'h24, 8'h25, 8'h26, 8'h29, 8'h30, 8'h31, 8'h35, 8'h36,
      8'h41, 8'h45, 8'h46, 8'h49, 8'h50, 8'h51, 8'h55, 8'h56,
      8'h61, 8'h65, 8'h66, 8'h69, 8'h70, 8'h71, 8'h75, 8'h76,
      8'h81, 8'h84, 8'h85, 8'h86, 8'h90, 8'h91, 8'h94, 8'h95, 8'h96,
      8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6, 8'hA9, 8'hB0, 8'hB1, 8'hB4, 8'hB5, 8'hB6,
      8'hC0, 8'hC1, 8'hC4, 8'hC5, 8'hC6, 8'hC9, 8'hD0, 8'hD1, 8'hD5, 8'hD6,
      8'hE0, 8'hE1, 8'hE4, 8'hE5, 8'hE6, 8'hE9, 8'hF0, 8'hF1, 8'hF5, 8'hF6: o_len = LEN_2;
      8'h0D, 8'h0E, 8'h19, 8'h1D, 8'h1E,
      8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h39, 8'h3D, 8'h3E,
      8'h4C, 8'h4D, 8'h4E, 8'h59, 8'h5D, 8'h5E,
      8'h6C, 8'h6D, 8'h6E, 8'h79, 8'h7D, 8'h7E,
      8'h8C, 8'h8D, 8'h8E, 8'h99, 8'h9D,
      8'hAC, 8'hAD, 8'hAE, 8'hB9, 8'hBC, 8'hBD, 8'hBE,
      8'hCC, 8'hCD, 8'hCE, 8'hD9, 8'hDD, 8'hDE,
      8'hEC, 8'hED, 8'hEE, 8'hF9, 8'hFD, 8'hFE: o_len = LEN_3;
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: 6502 fetch stage; reads opcode and operands, hands a bundle to decode, and owns PC writes.
// Define CPU_FETCH_ILLEGAL_EN to add the instr_illegal output.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_op_lo,
  output logic [7:0]  instr_op_hi,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
`ifdef CPU_FETCH_ILLEGAL_EN
  output logic        instr_illegal,
`endif
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc_out,
  output logic        pc_we
);
  fetch_state_t r_state, w_next;
  logic [15:0] r_fptr, r_ipc;
  logic [7:0]  r_opcode, r_op_lo, r_op_hi;
  logic [1:0]  r_len, w_raw_len, w_len;
  logic        w_ill, w_accept;
  opcode_length u_len (
    .i_opcode (mem_rdata),
    .o_len    (w_raw_len),
    .o_illegal(w_ill)
  );
  assign w_len = w_ill ? LEN_1 : w_raw_len;
  always_comb begin
    w_accept = (r_state == S_OUT) && instr_ready;
    pc_we = !reset && (redirect || w_accept);
    pc_out = redirect ? redirect_pc : r_fptr + {14'd0, r_len};
    mem_rd = (r_state == S_OP) || (r_state == S_B0 && w_len != LEN_1) || (r_state == S_B1 && r_len == LEN_3);
    mem_addr = r_fptr + (r_state == S_B0 ? 16'd1 : r_state == S_B1 ? 16'd2 : 16'd0);
    instr_valid = r_state == S_OUT;
    w_next = redirect ? S_OP :
             r_state == S_IDLE ? S_OP :
             r_state == S_OP ? S_B0 :
             r_state == S_B0 ? (w_len == LEN_1 ? S_OUT : S_B1) :
             r_state == S_B1 ? (r_len == LEN_3 ? S_B2 : S_OUT) :
             r_state == S_B2 ? S_OUT :
             r_state == S_OUT ? (instr_ready ? S_OP : S_OUT) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_fptr <= RESET_PC;
      r_ipc <= 16'd0;
      r_opcode <= 8'd0;
      r_op_lo <= 8'd0;
      r_op_hi <= 8'd0;
      r_len <= 2'd0;
    end else begin
      r_state <= w_next;
      if (pc_we) r_fptr <= pc_out;
      // operands are cleared at opcode capture so unused bytes read as zero
      if (r_state == S_B0) begin
        r_opcode <= mem_rdata;
        r_ipc <= r_fptr;
        r_len <= w_len;
        r_op_lo <= 8'd0;
        r_op_hi <= 8'd0;
      end
      if (r_state == S_B1) r_op_lo <= mem_rdata;
      if (r_state == S_B2) r_op_hi <= mem_rdata;
    end
  end
`ifdef CPU_FETCH_ILLEGAL_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (reset) r_illegal <= 1'b0;
    else if (r_state == S_B0) r_illegal <= w_ill;
  end
  assign instr_illegal = r_illegal;
`endif
  assign instr_opcode = r_opcode;
  assign instr_op_lo = r_op_lo;
  assign instr_op_hi = r_op_hi;
  assign instr_len = r_len;
  assign instr_pc = r_ipc;
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed self-checking bench for cpu_fetch with a 1-cycle synchronous byte memory.
module tb_cpu_fetch;
  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_rd, instr_valid, pc_we;
  logic        instr_ready = 1'b0, redirect = 1'b0;
  logic [15:0] mem_addr, instr_pc, pc_out;
  logic [15:0] redirect_pc = 16'd0;
  logic [7:0]  mem_rdata = 8'd0, instr_opcode, instr_op_lo, instr_op_hi;
  logic [1:0]  instr_len;
`ifdef CPU_FETCH_ILLEGAL_EN
  logic        instr_illegal;
`endif
  int checks = 0, errors = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log [$];
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) begin
    mem_rdata <= mem[mem_addr];
    rd_log.push_back(mem_addr);
  end
  cpu_fetch #(.RESET_PC(16'h1000)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_op_lo(instr_op_lo), .instr_op_hi(instr_op_hi), .instr_len(instr_len), .instr_pc(instr_pc),
`ifdef CPU_FETCH_ILLEGAL_EN
    .instr_illegal(instr_illegal),
`endif
    .redirect(redirect), .redirect_pc(redirect_pc), .pc_out(pc_out), .pc_we(pc_we)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h5555; instr_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({pc_we, mem_rd, instr_valid, mem_addr} !== {3'b000, 16'h1000}) begin
      errors++;
      $display("FAIL reset_ctrl: got we/rd/valid/addr=%b%b%b/%h required 000/1000", pc_we, mem_rd, instr_valid, mem_addr);
    end
    checks++;
    if ({instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc} !== 42'd0) begin
      errors++;
      $display("FAIL reset_bundle: got %h required 0", {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc});
    end
    redirect = 1'b0; instr_ready = 1'b0; reset = 1'b0;
  endtask
  task automatic test_len2;
    int n;
    wait_valid(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL len2_latency: got %0d required 4", n); end
    checks++;
    if ({instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc} !== {8'hA9, 8'h42, 8'h00, 2'd2, 16'h1000}) begin
      errors++;
      $display("FAIL len2_bundle: got %h required %h", {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, {8'hA9, 8'h42, 8'h00, 2'd2, 16'h1000});
    end
    instr_ready = 1'b1;
    #1;
    checks++;
    if ({pc_we, pc_out} !== {1'b1, 16'h1002}) begin errors++; $display("FAIL len2_pc: got we=%b pc=%h required we=1 pc=1002", pc_we, pc_out); end
    tick();
    instr_ready = 1'b0;
  endtask
  task automatic test_stall;
    int n;
    wait_valid(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL len3_latency: got %0d required 4", n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({instr_valid, mem_rd, pc_we, instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc} !== {3'b100, 8'hAD, 8'h34, 8'h12, 2'd3, 16'h1002}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v/rd/we=%b%b%b bundle=%h required 100 bundle=%h", i, instr_valid, mem_rd, pc_we,
                 {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, {8'hAD, 8'h34, 8'h12, 2'd3, 16'h1002});
      end
    end
    instr_ready = 1'b1;
    #1;
    checks++;
    if ({pc_we, pc_out} !== {1'b1, 16'h1005}) begin errors++; $display("FAIL len3_pc: got we=%b pc=%h required we=1 pc=1005", pc_we, pc_out); end
    tick();
    instr_ready = 1'b0;
  endtask
  task automatic test_len1;
    int n;
    wait_valid(n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL len1_latency: got %0d required 2", n); end
    checks++;
    if ({instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc} !== {8'hEA, 8'h00, 8'h00, 2'd1, 16'h1005}) begin
      errors++;
      $display("FAIL len1_bundle: got %h required %h", {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, {8'hEA, 8'h00, 8'h00, 2'd1, 16'h1005});
    end
    instr_ready = 1'b1;
    #1;
    checks++;
    if ({pc_we, pc_out} !== {1'b1, 16'h1006}) begin errors++; $display("FAIL len1_pc: got we=%b pc=%h required we=1 pc=1006", pc_we, pc_out); end
  endtask
  task automatic test_back_to_back;
    logic exp_we;
    logic [15:0] exp_pc;
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_we = (i % 3 == 2);
      exp_pc = 16'h1006 + 16'((i + 1) / 3);
      checks++;
      if (pc_we !== exp_we || (exp_we && pc_out !== exp_pc)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got we=%b pc=%h required we=%b pc=%h", i, pc_we, pc_out, exp_we, exp_pc);
      end
    end
    instr_ready = 1'b0;
  endtask
  task automatic test_redirect_b1;
    int n;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 16'h2000;
    #1;
    checks++;
    if ({instr_valid, pc_we, pc_out} !== {2'b01, 16'h2000}) begin
      errors++;
      $display("FAIL redir_b1: got v=%b we=%b pc=%h required v=0 we=1 pc=2000", instr_valid, pc_we, pc_out);
    end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if ({instr_valid, mem_rd, mem_addr} !== {2'b01, 16'h2000}) begin
      errors++;
      $display("FAIL redir_b1_next: got v=%b rd=%b addr=%h required v=0 rd=1 addr=2000", instr_valid, mem_rd, mem_addr);
    end
    wait_valid(n);
    checks++;
    if (n != 2 || instr_pc !== 16'h2000 || instr_opcode !== 8'hEA) begin
      errors++;
      $display("FAIL redir_b1_fetch: got n=%0d pc=%h op=%h required n=2 pc=2000 op=EA", n, instr_pc, instr_opcode);
    end
  endtask
  task automatic test_redirect_accept;
    int n;
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h3000;
    #1;
    checks++;
    if ({pc_we, pc_out} !== {1'b1, 16'h3000}) begin errors++; $display("FAIL redir_accept_pc: got we=%b pc=%h required we=1 pc=3000", pc_we, pc_out); end
    tick();
    instr_ready = 1'b0; redirect = 1'b0;
    #1;
    checks++;
    if ({instr_valid, mem_rd, mem_addr} !== {2'b01, 16'h3000}) begin
      errors++;
      $display("FAIL redir_accept_next: got v=%b rd=%b addr=%h required v=0 rd=1 addr=3000", instr_valid, mem_rd, mem_addr);
    end
    wait_valid(n);
    checks++;
    if (n != 3 || {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc} !== {8'hA9, 8'h55, 8'h00, 2'd2, 16'h3000}) begin
      errors++;
      $display("FAIL redir_accept_fetch: got n=%0d bundle=%h required n=3 bundle=%h", n,
               {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, {8'hA9, 8'h55, 8'h00, 2'd2, 16'h3000});
    end
  endtask
  task automatic test_wrap;
    int n;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    rd_log.delete();
    wait_valid(n);
    checks++;
    if (n != 4 || rd_log.size() != 3) begin
      errors++;
      $display("FAIL wrap_reads: got n=%0d reads=%0d required n=4 reads=3", n, rd_log.size());
    end else if ({rd_log[0], rd_log[1], rd_log[2]} !== {16'hFFFE, 16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_addrs: got %h %h %h required FFFE FFFF 0000", rd_log[0], rd_log[1], rd_log[2]);
    end
    checks++;
    if ({instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc} !== {8'h4C, 8'h00, 8'h80, 2'd3, 16'hFFFE}) begin
      errors++;
      $display("FAIL wrap_bundle: got %h required %h", {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, {8'h4C, 8'h00, 8'h80, 2'd3, 16'hFFFE});
    end
    instr_ready = 1'b1;
    #1;
    checks++;
    if ({pc_we, pc_out} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL wrap_pc: got we=%b pc=%h required we=1 pc=0001", pc_we, pc_out); end
    tick();
    instr_ready = 1'b0;
  endtask
  task automatic test_illegal;
    int n;
    wait_valid(n);
    checks++;
    if (n != 2 || {instr_opcode, instr_len, instr_pc} !== {8'h02, 2'd1, 16'h0001}) begin
      errors++;
      $display("FAIL illegal_len: got n=%0d op=%h len=%0d pc=%h required n=2 op=02 len=1 pc=0001", n, instr_opcode, instr_len, instr_pc);
    end
`ifdef CPU_FETCH_ILLEGAL_EN
    checks++;
    if (instr_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag02: got %b required 1", instr_illegal); end
`endif
    instr_ready = 1'b1;
    #1;
    checks++;
    if ({pc_we, pc_out} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL illegal_pc: got we=%b pc=%h required we=1 pc=0002", pc_we, pc_out); end
    tick();
    instr_ready = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 3 || {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc} !== {8'hA9, 8'h01, 8'h00, 2'd2, 16'h0002}) begin
      errors++;
      $display("FAIL legal_after: got n=%0d bundle=%h required n=3 bundle=%h", n,
               {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, {8'hA9, 8'h01, 8'h00, 2'd2, 16'h0002});
    end
`ifdef CPU_FETCH_ILLEGAL_EN
    checks++;
    if (instr_illegal !== 1'b0) begin errors++; $display("FAIL illegal_flagA9: got %b required 0", instr_illegal); end
`endif
  endtask
  task automatic test_reset_override;
    reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h4444; instr_ready = 1'b1;
    #1;
    checks++;
    if (pc_we !== 1'b0) begin errors++; $display("FAIL reset_over_we: got %b required 0", pc_we); end
    tick();
    checks++;
    if ({instr_valid, mem_rd, mem_addr, instr_opcode, instr_len} !== {2'b00, 16'h1000, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL reset_over_state: got v=%b rd=%b addr=%h op=%h len=%0d required 0 0 1000 00 0", instr_valid, mem_rd, mem_addr, instr_opcode, instr_len);
    end
    redirect = 1'b0; instr_ready = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h1000] = 8'hA9; mem[16'h1001] = 8'h42;
    mem[16'h1002] = 8'hAD; mem[16'h1003] = 8'h34; mem[16'h1004] = 8'h12;
    mem[16'h1009] = 8'h4C; mem[16'h100A] = 8'h11; mem[16'h100B] = 8'h22;
    mem[16'h3000] = 8'hA9; mem[16'h3001] = 8'h55;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
    mem[16'h0001] = 8'h02; mem[16'h0002] = 8'hA9; mem[16'h0003] = 8'h01;
    test_reset();
    test_len2();
    test_stall();
    test_len1();
    test_back_to_back();
    test_redirect_b1();
    test_redirect_accept();
    test_wrap();
    test_illegal();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
